// File: rtl/hclk_gen.sv
// hclk_gen: derives a slow bus clock HCLK from the fast system clock with
// programmable low/high phase lengths, plus single-cycle edge strobes.
//
// Ports:
//   clk        system clock, all logic on rising edge
//   n_rst      synchronous active-low reset
//   enable     1 = run HCLK, 0 = park high after the current full cycle
//   lo_len     low phase length in clk cycles (0 treated as 1)
//   hi_len     high phase length in clk cycles (0 treated as 1)
//   HCLK       generated clock, registered
//   HCLK_rise  one-cycle strobe coincident with HCLK going 0->1
//   HCLK_fall  one-cycle strobe coincident with HCLK going 1->0
//   busy       1 whenever the generator is not idle
//   cycle_cnt  count of HCLK rising edges generated, wraps
module hclk_gen #(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned EDGE_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  enable,
    input  logic [CNT_W-1:0]      lo_len,
    input  logic [CNT_W-1:0]      hi_len,
    output logic                  HCLK,
    output logic                  HCLK_rise,
    output logic                  HCLK_fall,
    output logic                  busy,
    output logic [EDGE_CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StHigh
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lo_load;
    logic [CNT_W-1:0] hi_load;

    // Counter reload value is L-1 with L = max(len, 1), so a zero length
    // still yields a one-cycle phase.
    always_comb begin
        lo_load = '0;
        hi_load = '0;
        if (lo_len != '0) lo_load = lo_len - CNT_W'(1);
        if (hi_len != '0) hi_load = hi_len - CNT_W'(1);
    end

    // Lengths are only sampled on phase entry, so mid-phase reprogramming
    // cannot shorten or stretch the phase in progress.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state     <= StIdle;
            HCLK      <= 1'b1;
            HCLK_rise <= 1'b0;
            HCLK_fall <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
            cycle_cnt <= '0;
        end else begin
            HCLK_rise <= 1'b0;
            HCLK_fall <= 1'b0;
            unique case (state)
                StIdle: begin
                    HCLK <= 1'b1;
                    busy <= 1'b0;
                    if (enable) begin
                        state     <= StLow;
                        HCLK      <= 1'b0;
                        HCLK_fall <= 1'b1;
                        cnt       <= lo_load;
                        busy      <= 1'b1;
                    end
                end
                // enable is deliberately ignored here: a started cycle completes.
                StLow: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state     <= StHigh;
                        HCLK      <= 1'b1;
                        HCLK_rise <= 1'b1;
                        cnt       <= hi_load;
                        cycle_cnt <= cycle_cnt + EDGE_CNT_W'(1);
                    end
                end
                StHigh: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (enable) begin
                        state     <= StLow;
                        HCLK      <= 1'b0;
                        HCLK_fall <= 1'b1;
                        cnt       <= lo_load;
                    end else begin
                        // Park high with no strobe; HCLK is already 1.
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                    HCLK  <= 1'b1;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hclk_gen.sv
// Directed self-checking bench for hclk_gen. A second instance with a 4-bit
// cycle counter exercises counter wrap.
module tb_hclk_gen;

    logic        clk = 1'b0;
    logic        n_rst, enable;
    logic [7:0]  lo_len, hi_len;
    logic        hclk, hclk_rise, hclk_fall, busy;
    logic [15:0] cycle_cnt;

    logic        w_rst, w_en;
    logic [7:0]  w_lo, w_hi;
    logic        w_hclk, w_rise, w_fall, w_busy;
    logic [3:0]  w_cnt;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    hclk_gen #(.CNT_W(8), .EDGE_CNT_W(16)) dut (
        .clk(clk), .n_rst(n_rst), .enable(enable), .lo_len(lo_len), .hi_len(hi_len),
        .HCLK(hclk), .HCLK_rise(hclk_rise), .HCLK_fall(hclk_fall), .busy(busy),
        .cycle_cnt(cycle_cnt)
    );

    hclk_gen #(.CNT_W(8), .EDGE_CNT_W(4)) dut_w (
        .clk(clk), .n_rst(w_rst), .enable(w_en), .lo_len(w_lo), .hi_len(w_hi),
        .HCLK(w_hclk), .HCLK_rise(w_rise), .HCLK_fall(w_fall), .busy(w_busy),
        .cycle_cnt(w_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input logic h, input logic r, input logic f,
                           input logic b);
        chk({tag, ".HCLK"}, {31'd0, hclk}, {31'd0, h});
        chk({tag, ".rise"}, {31'd0, hclk_rise}, {31'd0, r});
        chk({tag, ".fall"}, {31'd0, hclk_fall}, {31'd0, f});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    endtask

    initial begin
        n_rst = 1'b0; enable = 1'b0; lo_len = 8'd3; hi_len = 8'd2;
        w_rst = 1'b0; w_en = 1'b0; w_lo = 8'd1; w_hi = 8'd1;
        tick();
        tick();
        chk_out("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset.cycle_cnt", {16'd0, cycle_cnt}, 32'd0);
        chk("reset_w.HCLK", {31'd0, w_hclk}, 32'd1);

        // lo=3 hi=2: fall one clk after enable, then 0,0,0,1,1 per period.
        n_rst = 1'b1; w_rst = 1'b1; enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_out($sformatf("p5[%0d]", i), (i % 5) >= 3, (i % 5) == 3, (i % 5) == 0, 1'b1);
        end
        chk("p5.cycle_cnt", {16'd0, cycle_cnt}, 32'd4);

        // Zero lengths behave as 1: toggles every clk, strobes alternate.
        lo_len = 8'd0; hi_len = 8'd0;
        for (int j = 0; j < 6; j++) begin
            tick();
            chk_out($sformatf("p2[%0d]", j), (j % 2) == 1, (j % 2) == 1, (j % 2) == 0, 1'b1);
        end
        chk("p2.cycle_cnt", {16'd0, cycle_cnt}, 32'd7);

        // lo=hi=4, drop enable during LOW: full cycle completes, then parks.
        lo_len = 8'd4; hi_len = 8'd4;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk_out($sformatf("stop[%0d]", k), k >= 4, k == 4, k == 0, k < 8);
            if (k == 1) enable = 1'b0;
        end
        chk("stop.cycle_cnt", {16'd0, cycle_cnt}, 32'd8);

        // lo 2->6 mid-low: current low stays 2, next low is 6.
        lo_len = 8'd2; hi_len = 8'd1; enable = 1'b1;
        for (int m = 0; m < 10; m++) begin
            tick();
            chk_out($sformatf("reprog[%0d]", m), m == 2 || m == 9, m == 2 || m == 9,
                    m == 0 || m == 3, 1'b1);
            if (m == 0) lo_len = 8'd6;
        end
        chk("reprog.cycle_cnt", {16'd0, cycle_cnt}, 32'd10);

        // Reset during LOW forces HCLK high, then restarts with enable held.
        tick();
        chk_out("pre_rst", 1'b0, 1'b0, 1'b1, 1'b1);
        n_rst = 1'b0;
        tick();
        chk_out("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("mid_rst.cycle_cnt", {16'd0, cycle_cnt}, 32'd0);
        n_rst = 1'b1;
        tick();
        chk_out("restart", 1'b0, 1'b0, 1'b1, 1'b1);

        // 4-bit counter wrap with lo=hi=1: rise n lands on edge 2n-1.
        w_en = 1'b1;
        for (int n = 0; n < 30; n++) tick();
        chk("wrap.15", {28'd0, w_cnt}, 32'd15);
        tick();
        tick();
        chk("wrap.0", {28'd0, w_cnt}, 32'd0);
        tick();
        tick();
        chk("wrap.1", {28'd0, w_cnt}, 32'd1);
        chk("wrap.rise", {29'd0, w_hclk, w_rise, w_fall}, 32'b110);
        chk("wrap.busy", {31'd0, w_busy}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/hclk_gen.md
Name: hclk_gen

Overview:
- Generates a slow bus clock HCLK from the fast system clock `clk`, with programmable low and high phase lengths.
- Emits single-cycle rise and fall strobes aligned with each HCLK transition, so local logic does not need to detect edges itself.
- Acts as the driving end of the HCLK link: off-chip or downstream logic samples this HCLK, and our receive-side edge detection recovers the edges.
- Guarantees no runt pulses when started, stopped or reprogrammed.

Parameters:
- CNT_W, 8, width of the phase-length inputs and of the internal phase counter.
- EDGE_CNT_W, 16, width of the completed-cycle counter output.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- n_rst  input  1  synchronous active-low reset.
- enable  input  1  level; 1 = run HCLK, 0 = park HCLK high after the current full cycle.
- lo_len  input  CNT_W  HCLK low phase length in clk cycles; 0 treated as 1.
- hi_len  input  CNT_W  HCLK high phase length in clk cycles; 0 treated as 1.
- HCLK  output  1  generated clock, registered.
- HCLK_rise  output  1  one-cycle strobe, high in the first cycle HCLK reads 1 after a 0.
- HCLK_fall  output  1  one-cycle strobe, high in the first cycle HCLK reads 0 after a 1.
- busy  output  1  1 whenever state is not IDLE.
- cycle_cnt  output  EDGE_CNT_W  number of HCLK rising edges generated; wraps modulo 2^EDGE_CNT_W.

Behaviour:
- Reset (n_rst=0 at a clk edge; synchronous, overrides everything):
  - state=IDLE, HCLK=1, HCLK_rise=0, HCLK_fall=0, busy=0, cnt=0, cycle_cnt=0.
  - Reset mid-cycle forces HCLK high on the next edge. This may truncate a low phase; that is accepted.
- All outputs are registered. Strobes and HCLK change on the same clk edge, so each strobe is coincident with the new HCLK level.
- Phase-length sampling:
  - lo_len is sampled only when a low phase is entered; hi_len only when a high phase is entered.
  - Changing either input mid-phase has no effect until the next phase of that type (glitch-free reprogramming).
  - Effective length L = max(len,1). cnt loads L-1.
- IDLE:
  - HCLK=1, busy=0.
  - If enable=1: next edge state=LOW, HCLK=0, HCLK_fall=1, cnt=L_lo-1, busy=1.
  - Latency from enable rising to HCLK falling is one clk.
- LOW:
  - HCLK=0.
  - If cnt!=0: cnt decrements.
  - If cnt==0: next edge state=HIGH, HCLK=1, HCLK_rise=1, cnt=L_hi-1, cycle_cnt increments.
  - enable is ignored in LOW; a started cycle always completes.
- HIGH:
  - HCLK=1.
  - If cnt!=0: cnt decrements.
  - If cnt==0 and enable=1: next edge state=LOW, HCLK=0, HCLK_fall=1, cnt=L_lo-1.
  - If cnt==0 and enable=0: next edge state=IDLE, busy=0, no strobe, HCLK stays 1.
- Timing:
  - HCLK is low for exactly L_lo clk cycles and high for exactly L_hi cycles. Period = L_lo+L_hi.
  - Minimum period is 2 clk (lo_len=hi_len=1 or 0).
- HCLK_rise and HCLK_fall are never both 1. Each lasts exactly one cycle.
- Enable pulses shorter than a full cycle in IDLE still produce exactly one complete HCLK cycle, provided enable is 1 on the IDLE edge that starts it.
- cycle_cnt wraps from 2^EDGE_CNT_W-1 to 0 and is cleared only by reset.

Test Plan:
- Reset then enable=1, lo_len=3, hi_len=2:
  - HCLK falls 1 clk after enable.
  - Pattern per period is 0,0,0,1,1 (period 5).
  - HCLK_fall and HCLK_rise each 1 cycle, coincident with transitions.
  - cycle_cnt = 4 after 4 rises.
- lo_len=0, hi_len=0, enable=1 -> HCLK toggles every clk (period 2); strobes alternate every cycle.
- Free-running lo=4, hi=4; drop enable mid-LOW:
  - Low phase completes (4 cycles), then high phase completes (4 cycles).
  - State IDLE, HCLK=1, busy=0, no extra strobes.
- Change lo_len 2->6 in the middle of a low phase -> current low phase stays 2 cycles; the next low phase is 6 cycles; no glitch.
- Assert n_rst=0 for one cycle during LOW:
  - Next edge HCLK=1, strobes 0, cycle_cnt=0, busy=0.
  - With enable still 1, HCLK restarts with a fall one clk after reset releases.
- EDGE_CNT_W=4, lo=hi=1, run 17 rises -> cycle_cnt wraps: reads 15, 0, 1.
